// File: rtl/batch_cycle_scheduler.sv
// batch_cycle_scheduler: sample-index counters, 4-phase bank rotation, batch pulse,
// 3-stage index/cycle delay line and primed flag, all advancing on the downsample strobe.
module batch_cycle_scheduler #(
    parameter int depth = 32,
    parameter int DSR   = 1,
    localparam int DSD  = (depth + DSR - 1) / DSR,
    localparam int CW   = $clog2(DSD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [CW-1:0]        dBatCount,
    output logic [CW-1:0]        dBatCountRev,
    output logic [1:0]           cycle,
    output logic [1:0]           cycleLH,
    output logic [1:0]           cycleIdle,
    output logic [1:0]           cycleCalc,
    output logic                 cyclePulse,
    output logic [2:0][CW-1:0]   delayBatCount,
    output logic [2:0][CW-1:0]   delayBatCountRev,
    output logic [2:0][1:0]      delayCycle,
    output logic                 primed
);
    localparam logic [CW-1:0] LAST = CW'(DSD - 1);
    logic       wrap;
    logic [1:0] tally;
    assign wrap = dBatCount == LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            dBatCount        <= '0;
            dBatCountRev     <= LAST;
            cycle            <= 2'd0;
            cycleLH          <= 2'd3;
            cycleIdle        <= 2'd2;
            cycleCalc        <= 2'd1;
            cyclePulse       <= 1'b0;
            delayBatCount    <= '0;
            delayBatCountRev <= {3{LAST}};
            delayCycle       <= '0;
            tally            <= 2'd0;
            primed           <= 1'b0;
        end else if (en) begin
            delayBatCount    <= {delayBatCount[1:0], dBatCount};
            delayBatCountRev <= {delayBatCountRev[1:0], dBatCountRev};
            delayCycle       <= {delayCycle[1:0], cycle};
            cyclePulse       <= wrap;
            dBatCount        <= wrap ? '0 : dBatCount + 1'b1;
            dBatCountRev     <= wrap ? LAST : dBatCountRev - 1'b1;
            if (wrap) begin
                // roles are the new cycle minus 1, 2, 3 (mod 4)
                cycle     <= cycle + 2'd1;
                cycleLH   <= cycle;
                cycleIdle <= cycle - 2'd1;
                cycleCalc <= cycle - 2'd2;
                tally     <= (tally == 2'd3) ? tally : tally + 2'd1;
                primed    <= primed | (tally == 2'd2);
            end
        end
    end
endmodule

// File: tb/tb_batch_cycle_scheduler.sv
// tb_batch_cycle_scheduler: directed checks on a DSD=32 instance and a DSD=11 (DSR=3) instance.
module tb_batch_cycle_scheduler;
    logic clk = 1'b0;
    logic rst, en_a, en_b;
    always #5 clk = ~clk;

    logic [4:0] a_cnt, a_rev;
    logic [1:0] a_cyc, a_lh, a_idle, a_calc;
    logic a_pulse, a_primed;
    logic [2:0][4:0] a_dcnt, a_drev;
    logic [2:0][1:0] a_dcyc;

    logic [3:0] b_cnt, b_rev;
    logic [1:0] b_cyc, b_lh, b_idle, b_calc;
    logic b_pulse, b_primed;
    logic [2:0][3:0] b_dcnt, b_drev;
    logic [2:0][1:0] b_dcyc;

    batch_cycle_scheduler #(.depth(32), .DSR(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .dBatCount(a_cnt), .dBatCountRev(a_rev), .cycle(a_cyc), .cycleLH(a_lh),
        .cycleIdle(a_idle), .cycleCalc(a_calc), .cyclePulse(a_pulse),
        .delayBatCount(a_dcnt), .delayBatCountRev(a_drev), .delayCycle(a_dcyc),
        .primed(a_primed)
    );

    batch_cycle_scheduler #(.depth(32), .DSR(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .dBatCount(b_cnt), .dBatCountRev(b_rev), .cycle(b_cyc), .cycleLH(b_lh),
        .cycleIdle(b_idle), .cycleCalc(b_calc), .cyclePulse(b_pulse),
        .delayBatCount(b_dcnt), .delayBatCountRev(b_drev), .delayCycle(b_dcyc),
        .primed(b_primed)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic ea, input logic eb);
        en_a = ea;
        en_b = eb;
        @(negedge clk);
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_cnt"}, a_cnt, 0);
        check({tag, "_rev"}, a_rev, 31);
        check({tag, "_cyc"}, a_cyc, 0);
        check({tag, "_lh"}, a_lh, 3);
        check({tag, "_idle"}, a_idle, 2);
        check({tag, "_calc"}, a_calc, 1);
        check({tag, "_pulse"}, a_pulse, 0);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_dcnt"}, a_dcnt[k], 0);
            check({tag, "_drev"}, a_drev[k], 31);
            check({tag, "_dcyc"}, a_dcyc[k], 0);
        end
        check({tag, "_primed"}, a_primed, 0);
    endtask

    task automatic check_b_reset(input string tag);
        check({tag, "_b_cnt"}, b_cnt, 0);
        check({tag, "_b_rev"}, b_rev, 10);
        check({tag, "_b_cyc"}, b_cyc, 0);
        check({tag, "_b_calc"}, b_calc, 1);
        check({tag, "_b_drev2"}, b_drev[2], 10);
        check({tag, "_b_primed"}, b_primed, 0);
    endtask

    initial begin
        int s;
        int hc[$];
        int hy[$];
        rst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (2) @(negedge clk);
        check_a_reset("t1_rst");
        check_b_reset("t1_rst");
        rst = 1'b0;
        repeat (10) tick(0, 0);
        check_a_reset("t1_hold");
        check_b_reset("t1_hold");

        // DSD=11, one strobe every third clock
        s = 0;
        for (int i = 0; i < 75; i++) begin
            tick(0, (i % 3) == 0);
            if ((i % 3) == 0) s++;
            check("t3_cnt", b_cnt, s % 11);
            check("t3_rev", b_rev, 10 - (s % 11));
            check("t3_range", int'(b_cnt <= 4'd10), 1);
            check("t3_pulse", b_pulse, int'((s % 11) == 0 && s > 0));
            check("t3_cyc", b_cyc, (s / 11) % 4);
        end

        for (int k = 1; k <= 40; k++) begin
            tick(1, 0);
            check("t2_cnt", a_cnt, k % 32);
            check("t2_rev", a_rev, 31 - (k % 32));
            check("t2_pulse", a_pulse, int'(k == 32));
            if (k == 32) begin
                check("t2_cyc", a_cyc, 1);
                check("t2_lh", a_lh, 0);
                check("t2_idle", a_idle, 3);
                check("t2_calc", a_calc, 2);
            end
        end
        tick(0, 0);
        check("t2_hold_cnt", a_cnt, 8);
        check("t2_dcnt0", a_dcnt[0], 7);
        check("t2_dcnt2", a_dcnt[2], 5);
        check("t2_drev2", a_drev[2], 26);

        for (int k = 41; k <= 128; k++) begin
            tick(1, 0);
            check("t4_primed", a_primed, int'(k >= 96));
            check("t4_cyc", a_cyc, (k / 32) % 4);
            if (k == 128) begin
                check("t4_lh", a_lh, 3);
                check("t4_idle", a_idle, 2);
                check("t4_calc", a_calc, 1);
            end
        end

        // history of (count, cycle) after strobes 125..128
        hc = '{29, 30, 31, 0};
        hy = '{3, 3, 3, 0};
        for (int i = 0; i < 25; i++) begin
            logic e;
            e = (i < 5) || ((i - 5) % 2 == 0);
            tick(e, 0);
            if (e) begin
                int m;
                m = (hc[$] + 1) % 32;
                hy.push_back(m == 0 ? (hy[$] + 1) % 4 : hy[$]);
                hc.push_back(m);
            end
            check("t5_cnt", a_cnt, hc[$]);
            check("t5_dcnt0", a_dcnt[0], hc[$-1]);
            check("t5_dcnt2", a_dcnt[2], hc[$-3]);
            check("t5_drev2", a_drev[2], 31 - hc[$-3]);
            check("t5_dcyc2", a_dcyc[2], hy[$-3]);
        end

        repeat (66) tick(1, 0);
        check("t6_pre_cnt", a_cnt, 17);
        check("t6_pre_cyc", a_cyc, 2);
        check("t6_pre_primed", a_primed, 1);
        rst = 1'b1;
        tick(1, 1);
        check_a_reset("t6_rst");
        check_b_reset("t6_rst");
        rst = 1'b0;
        tick(1, 0);
        check("t6_restart", a_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
